// File: rtl/coletor_resultados.sv
`default_nettype none
// ============================================================================
// Module   : coletor_resultados
// Purpose  : Result collector placed after the 3-operand signed accumulator.
//            Captures one {overflow, soma} pair on every rising edge of the
//            accumulator's pronto flag. It buffers the pairs in a small
//            first-word-fall-through FIFO and presents them on a valid/ready
//            interface. It also keeps saturating overflow and lost-result
//            statistics.
// Ports    : clk, reset        - clock, asynchronous active-high reset
//            pronto_in         - accumulator done flag (rising edge = new result)
//            soma_in           - accumulator result, sampled on the capture cycle
//            overflow_in       - accumulator overflow flag, sampled with soma_in
//            res_valid/ready   - head-of-FIFO handshake
//            res_soma, res_ovf - head result and its overflow flag
//            nivel             - FIFO occupancy (0..DEPTH)
//            ovf_cnt           - accepted results that had overflow (saturating)
//            perdidos          - results dropped on a full FIFO (saturating)
//            clr_stats         - synchronous clear of both statistics counters
// Options  : COLETOR_SATURA_EN - when defined, overflowed results are clamped
//            to the most positive / most negative value before storage.
// Revision : 1.0 - initial release
// ============================================================================
module coletor_resultados #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pronto_in,
  input  logic [WIDTH-1:0]         soma_in,
  input  logic                     overflow_in,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_soma,
  output logic                     res_ovf,
  output logic [$clog2(DEPTH):0]   nivel,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic [CNT_W-1:0]         perdidos,
  input  logic                     clr_stats
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int NIV_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] c_PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [NIV_W-1:0] c_NIV_ONE    = {{(NIV_W-1){1'b0}}, 1'b1};
  localparam logic [NIV_W-1:0] c_NIV_FULL   = NIV_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_SOMA_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_SOMA_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                 r_pronto_d;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [NIV_W-1:0]     r_nivel;
  logic [CNT_W-1:0]     r_ovf_cnt;
  logic [CNT_W-1:0]     r_perdidos;
  logic [WIDTH:0]       r_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  logic                 w_cap;
  logic                 w_valid;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [WIDTH-1:0]     w_dado;
  logic [WIDTH:0]       w_head;

  // pronto_d resets to 1 so that an accumulator idling with pronto high
  // after reset is not mistaken for a fresh result.
  assign w_cap   = pronto_in & ~r_pronto_d;
  assign w_valid = (r_nivel != '0);
  assign w_full  = (r_nivel == c_NIV_FULL);
  assign w_pop   = w_valid & res_ready;
  // A full FIFO still accepts the new result when the head leaves in the
  // same cycle; otherwise the result is lost.
  assign w_push  = w_cap & (~w_full | w_pop);
  assign w_drop  = w_cap & w_full & ~w_pop;

`ifdef COLETOR_SATURA_EN
  // The wrapped sum has the opposite sign of the true result: a set MSB
  // with overflow means the true value was too positive, and vice versa.
  always_comb begin
    w_dado = soma_in;
    if (overflow_in) begin
      w_dado = soma_in[WIDTH-1] ? c_SOMA_MAX : c_SOMA_MIN;
    end
  end
`else
  assign w_dado = soma_in;
`endif

  // --------------------------------------------------------------------------
  // Edge detector, pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pronto_d <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_nivel    <= '0;
    end else begin
      r_pronto_d <= pronto_in;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_nivel <= r_nivel + c_NIV_ONE;
        2'b01:   r_nivel <= r_nivel - c_NIV_ONE;
        default: r_nivel <= r_nivel;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible through the head once
  // the occupancy says it was written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {overflow_in, w_dado};
    end
  end

  // --------------------------------------------------------------------------
  // Statistics (clear wins over any increment in the same cycle)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_cnt  <= '0;
      r_perdidos <= '0;
    end else if (clr_stats) begin
      r_ovf_cnt  <= '0;
      r_perdidos <= '0;
    end else begin
      if (w_push && overflow_in && !(&r_ovf_cnt)) begin
        r_ovf_cnt <= r_ovf_cnt + c_CNT_ONE;
      end
      if (w_drop && !(&r_perdidos)) begin
        r_perdidos <= r_perdidos + c_CNT_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: head is forced to zero while empty so the reset values hold
  // without having to clear the storage array.
  // --------------------------------------------------------------------------
  assign w_head    = w_valid ? r_mem[r_rd_ptr] : '0;
  assign res_valid = w_valid;
  assign res_soma  = w_head[WIDTH-1:0];
  assign res_ovf   = w_head[WIDTH];
  assign nivel     = r_nivel;
  assign ovf_cnt   = r_ovf_cnt;
  assign perdidos  = r_perdidos;

endmodule
`default_nettype wire

// File: doc/coletor_resultados.md
Name: coletor_resultados

Overview:
- Downstream stage of the 3-operand 6-bit signed accumulator FSM.
- Consumes its soma/overflow/pronto outputs and captures one result per completed sum.
- Buffers results in a small FIFO and presents them on a valid/ready interface to the consumer (display/host logic).
- Keeps overflow and lost-result statistics.

Parameters:
- WIDTH, 6, result width in bits; two's-complement signed.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pronto_in  input  1  done flag from the accumulator; a rising edge marks a new valid result.
- soma_in  input  WIDTH  result from the accumulator; sampled on the capture cycle.
- overflow_in  input  1  signed-overflow flag from the accumulator; sampled with soma_in.
- res_valid  output  1  FIFO head holds a result.
- res_ready  input  1  consumer accepts the head this cycle.
- res_soma  output  WIDTH  head result value.
- res_ovf  output  1  head overflow flag.
- nivel  output  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf_cnt  output  CNT_W  captured results with overflow set; saturates at all-ones.
- perdidos  output  CNT_W  results dropped because the FIFO was full; saturates.
- clr_stats  input  1  synchronous clear of ovf_cnt and perdidos.

Behaviour:
- Reset (async, high):
  - FIFO empty: res_valid=0, nivel=0, res_soma=0, res_ovf=0.
  - ovf_cnt=0, perdidos=0.
  - pronto_d (registered copy of pronto_in) = 1, so the idle-high pronto after reset does not trigger a capture.
- Capture event:
  - cap = pronto_in & ~pronto_d, evaluated each cycle.
  - On cap, {overflow_in, soma_in} from that same cycle is written into the FIFO.
  - pronto_d <= pronto_in every cycle.
- Latency: a capture into an empty FIFO gives res_valid=1 on the next cycle. The head is first-word-fall-through; res_soma/res_ovf are valid whenever res_valid=1.
- Pop: when res_valid & res_ready, the head advances at the clock edge. res_ready is ignored when res_valid=0.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- nivel changes per cycle:
  - +1 on push without pop.
  - -1 on pop without push.
  - unchanged on simultaneous push and pop.
- Full (nivel==DEPTH) and cap:
  - With a pop in the same cycle: the push is accepted; nivel stays DEPTH.
  - Without a pop: the result is dropped, perdidos increments (saturating), and FIFO contents are unchanged.
- Empty and cap with res_ready=1: no pop occurs, because res_valid was 0 that cycle.
- Statistics:
  - ovf_cnt increments on each accepted push whose overflow_in=1. Dropped results do not count toward ovf_cnt.
  - clr_stats has priority over increments in the same cycle. It does not affect FIFO contents.
- Reset mid-operation: FIFO contents are discarded and all outputs return to their reset values immediately (asynchronous).
- No combinational path from pronto_in/soma_in to any output; all outputs are registered or read from registered storage.
- Recommended internal structure: one small FSM-free datapath with an edge detector, FIFO memory, and read/write pointers; no internal states beyond those.

Optional Feature:
- Macro: COLETOR_SATURA_EN.
- Defined: an overflowed result is saturated before storage.
  - soma_in MSB=1 with overflow_in=1 (positive overflow) stores 2^(WIDTH-1)-1 (6'b011111).
  - soma_in MSB=0 with overflow_in=1 (negative overflow) stores -2^(WIDTH-1) (6'b100000).
  - res_ovf is still 1 for these entries.
- Not defined: the raw wrapped soma_in is stored unchanged.

Test Plan:
- Reset with pronto_in held 1, then hold 1 for 5 cycles -> no capture; res_valid=0, nivel=0.
- pronto_in 0->1 with soma_in=6'd9, overflow_in=0 -> next cycle res_valid=1, res_soma=9, res_ovf=0, nivel=1. res_ready=1 for one cycle -> res_valid=0.
- pronto_in 0->1 with soma_in=6'b100001, overflow_in=1 -> stored flag=1 and ovf_cnt=1.
  - Without the macro: res_soma=6'b100001.
  - With COLETOR_SATURA_EN: res_soma=6'b011111.
- res_ready=0, then 5 capture events with values 1..5 -> nivel=4, perdidos=1. Draining yields 1,2,3,4 in order.
- FIFO full, cap and pop in the same cycle with value 7 -> nivel stays 4, perdidos unchanged, 7 emerges last.
- Assert reset while nivel=3 -> same cycle res_valid=0, nivel=0. Then clr_stats=1 coinciding with an overflow capture -> ovf_cnt=0.
